fwd_bypass_unit: RTL

FWD_BYPASS_UNIT -- requirements
Module: fwd_bypass_unit

---
 rtl/fwd_bypass_unit_pkg.sv | 19 +
 rtl/fwd_port_select.sv | 58 +++++
 rtl/fwd_bypass_unit.sv | 82 ++++++++
 3 files changed

// File: rtl/fwd_bypass_unit_pkg.sv
// Shared CPU package: bypass-select encoding, default datapath sizing and the
// dependency-distance counter type used by the forwarding/bypass unit.
package fwd_bypass_unit_pkg;

  localparam int FWD_DW_DEF     = 32;
  localparam int FWD_NSTAGE_DEF = 3;
  localparam int FWD_NSRC_DEF   = 2;
  localparam int FWD_TW_DEF     = 2;

  // Select value 0 picks the register-file read; stage k is encoded as k+1.
  localparam int FWD_SEL_ORIGIN = 0;

  typedef logic [FWD_TW_DEF-1:0] fwd_cnt_t;

  function automatic int fwd_sel_stage(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fwd_port_select.sv
// Per-read-port bypass selection: youngest matching in-flight writer decides
// between forwarding its result, keeping the register-file value, or stalling.
module fwd_port_select
  import fwd_bypass_unit_pkg::*;
#(
  parameter int DW     = FWD_DW_DEF,
  parameter int NSTAGE = FWD_NSTAGE_DEF,
  parameter int TW     = FWD_TW_DEF,
  parameter int SW     = $clog2(NSTAGE + 1)
) (
  input  logic [NSTAGE-1:0]         ent_valid,
  input  logic [NSTAGE-1:0][4:0]    ent_waddr,
  input  logic [NSTAGE-1:0][TW-1:0] ent_tnew,
  input  logic [4:0]                raddr,
  input  logic [TW-1:0]             tuse,
  input  logic [DW-1:0]             origin,
  input  logic [NSTAGE*DW-1:0]      stage_data,
  output logic [DW-1:0]             data,
  output logic [SW-1:0]             sel,
  output logic                      stall_req
);

  logic          hit;
  int            hit_idx;
  logic [TW-1:0] hit_tnew;
  logic [DW-1:0] hit_data;

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = 0;
    hit_tnew = '0;
    hit_data = '0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (ent_valid[k] && (ent_waddr[k] == raddr) && (raddr != 5'd0)) begin
        hit      = 1'b1;
        hit_idx  = k;
        hit_tnew = ent_tnew[k];
        hit_data = stage_data[k*DW +: DW];
      end
    end
  end

  always_comb begin
    sel       = SW'(FWD_SEL_ORIGIN);
    data      = origin;
    stall_req = 1'b0;
    if (hit) begin
      if (hit_tnew == '0) begin
        sel  = SW'(fwd_sel_stage(hit_idx));
        data = hit_data;
      end else if (hit_tnew > tuse) begin
        stall_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_bypass_unit.sv
// Tracks destination/readiness of in-flight writers in the downstream stages and
// produces bypassed operands plus the decode stall for every read port.
module fwd_bypass_unit
  import fwd_bypass_unit_pkg::*;
#(
  parameter int DW     = FWD_DW_DEF,
  parameter int NSTAGE = FWD_NSTAGE_DEF,
  parameter int NSRC   = FWD_NSRC_DEF,
  parameter int TW     = FWD_TW_DEF
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               issue_valid,
  input  logic [4:0]                         issue_waddr,
  input  logic [TW-1:0]                      issue_tnew,
  input  logic                               flush,
  input  logic [NSRC*5-1:0]                  src_raddr,
  input  logic [NSRC*TW-1:0]                 src_tuse,
  input  logic [NSRC*DW-1:0]                 src_origin,
  input  logic [NSTAGE*DW-1:0]               stage_data,
  output logic [NSRC*DW-1:0]                 src_data,
  output logic [NSRC*$clog2(NSTAGE+1)-1:0]   src_sel,
  output logic                               stall
);

  localparam int SW = $clog2(NSTAGE + 1);

  logic [NSTAGE-1:0]         valid_q, valid_d;
  logic [NSTAGE-1:0][4:0]    waddr_q, waddr_d;
  logic [NSTAGE-1:0][TW-1:0] tnew_q,  tnew_d;
  logic [NSRC-1:0]           stall_vec;

  assign stall = |stall_vec;

  always_comb begin
    valid_d    = '0;
    waddr_d    = '0;
    tnew_d     = '0;
    valid_d[0] = issue_valid && (issue_waddr != 5'd0) && !stall;
    waddr_d[0] = issue_waddr;
    tnew_d[0]  = issue_tnew;
    for (int k = 1; k < NSTAGE; k++) begin
      valid_d[k] = valid_q[k-1];
      waddr_d[k] = waddr_q[k-1];
      tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      waddr_q <= '0;
      tnew_q  <= '0;
    end else begin
      valid_q <= valid_d;
      waddr_q <= waddr_d;
      tnew_q  <= tnew_d;
    end
  end

  for (genvar p = 0; p < NSRC; p++) begin : g_port
    fwd_port_select #(
      .DW    (DW),
      .NSTAGE(NSTAGE),
      .TW    (TW),
      .SW    (SW)
    ) u_sel (
      .ent_valid (valid_q),
      .ent_waddr (waddr_q),
      .ent_tnew  (tnew_q),
      .raddr     (src_raddr[p*5 +: 5]),
      .tuse      (src_tuse[p*TW +: TW]),
      .origin    (src_origin[p*DW +: DW]),
      .stage_data(stage_data),
      .data      (src_data[p*DW +: DW]),
      .sel       (src_sel[p*SW +: SW]),
      .stall_req (stall_vec[p])
    );
  end

endmodule
